// File: rtl/ula_serial_ctrl.sv
// Bit-serial sequencer driving one external 1-bit ULA slice, LSB first, with carry recirculation.
// Optional: define ULA_BACK2BACK_EN to accept a new START during the FIN cycle.
module ula_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] OPA,
    input  logic [WIDTH-1:0] OPB,
    input  logic [3:0]       ALUOP,
    output logic             SL_A,
    output logic             SL_B,
    output logic             SL_AIN,
    output logic             SL_BIN,
    output logic             SL_CIN,
    output logic             SL_LESS,
    output logic [1:0]       SL_OP,
    input  logic             SL_RESULT,
    input  logic             SL_COUT,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] RESULT,
    output logic             ZERO,
    output logic             OVERFLOW
);
    localparam int CW = $clog2(WIDTH);

`ifdef ULA_BACK2BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, SHIFT, FIXUP, FIN} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [1:0]       op_q;
    logic             busy_q;
    logic             accept;
    logic             last;
    logic             carry_x;
    logic [WIDTH-1:0] res_nxt;

    assign accept  = START && (state == IDLE || (B2B && state == FIN));
    assign last    = (cnt == CW'(WIDTH - 1));
    assign carry_x = SL_CIN ^ SL_COUT;
    assign res_nxt = {SL_RESULT, RESULT[WIDTH-1:1]};
    // A back-to-back accept in FIN overlaps BUSY with the DONE pulse.
    assign BUSY    = busy_q | (B2B && state == FIN && START);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            op_q     <= '0;
            busy_q   <= 1'b0;
            DONE     <= 1'b0;
            RESULT   <= '0;
            ZERO     <= 1'b0;
            OVERFLOW <= 1'b0;
            SL_A     <= 1'b0;
            SL_B     <= 1'b0;
            SL_AIN   <= 1'b0;
            SL_BIN   <= 1'b0;
            SL_CIN   <= 1'b0;
            SL_LESS  <= 1'b0;
            SL_OP    <= 2'b00;
        end else if (accept) begin
            // Bit 0 is presented on the slice in the first SHIFT cycle.
            state    <= SHIFT;
            cnt      <= '0;
            a_sh     <= OPA >> 1;
            b_sh     <= OPB >> 1;
            op_q     <= ALUOP[1:0];
            busy_q   <= 1'b1;
            DONE     <= 1'b0;
            ZERO     <= 1'b0;
            OVERFLOW <= 1'b0;
            SL_A     <= OPA[0];
            SL_B     <= OPB[0];
            SL_AIN   <= ALUOP[3];
            SL_BIN   <= ALUOP[2];
            SL_CIN   <= ALUOP[2];
            SL_LESS  <= 1'b0;
            SL_OP    <= (ALUOP[1:0] == 2'b11) ? 2'b10 : ALUOP[1:0];
        end else begin
            case (state)
                IDLE: ;
                SHIFT: begin
                    RESULT <= res_nxt;
                    SL_CIN <= SL_COUT;
                    SL_A   <= a_sh[0];
                    SL_B   <= b_sh[0];
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        OVERFLOW <= op_q[1] & carry_x;
                        if (op_q == 2'b11) begin
                            // SLT: re-run the slice in LESS mode with the corrected sign.
                            state   <= FIXUP;
                            SL_OP   <= 2'b11;
                            SL_LESS <= SL_RESULT ^ carry_x;
                            SL_A    <= 1'b0;
                            SL_B    <= 1'b0;
                            SL_CIN  <= 1'b0;
                        end else begin
                            state   <= FIN;
                            DONE    <= 1'b1;
                            busy_q  <= 1'b0;
                            ZERO    <= (res_nxt == '0);
                            SL_A    <= 1'b0;
                            SL_B    <= 1'b0;
                            SL_AIN  <= 1'b0;
                            SL_BIN  <= 1'b0;
                            SL_CIN  <= 1'b0;
                            SL_LESS <= 1'b0;
                            SL_OP   <= 2'b00;
                        end
                    end
                end
                FIXUP: begin
                    state   <= FIN;
                    RESULT  <= {{(WIDTH-1){1'b0}}, SL_RESULT};
                    DONE    <= 1'b1;
                    busy_q  <= 1'b0;
                    ZERO    <= ~SL_RESULT;
                    SL_A    <= 1'b0;
                    SL_B    <= 1'b0;
                    SL_AIN  <= 1'b0;
                    SL_BIN  <= 1'b0;
                    SL_CIN  <= 1'b0;
                    SL_LESS <= 1'b0;
                    SL_OP   <= 2'b00;
                end
                FIN: begin
                    state <= IDLE;
                    DONE  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ula_serial_ctrl.sv
// Directed bench for ula_serial_ctrl with a behavioural 1-bit ULA slice attached.
module tb_ula_serial_ctrl;
    localparam int W = 8;

    logic         CLK = 1'b0;
    logic         RST, START;
    logic [W-1:0] OPA, OPB;
    logic [3:0]   ALUOP;
    logic         SL_A, SL_B, SL_AIN, SL_BIN, SL_CIN, SL_LESS;
    logic [1:0]   SL_OP;
    logic         SL_RESULT, SL_COUT;
    logic         BUSY, DONE;
    logic [W-1:0] RESULT;
    logic         ZERO, OVERFLOW;

    int checks = 0;
    int errors = 0;

    ula_serial_ctrl #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OPA(OPA), .OPB(OPB), .ALUOP(ALUOP),
        .SL_A(SL_A), .SL_B(SL_B), .SL_AIN(SL_AIN), .SL_BIN(SL_BIN), .SL_CIN(SL_CIN),
        .SL_LESS(SL_LESS), .SL_OP(SL_OP), .SL_RESULT(SL_RESULT), .SL_COUT(SL_COUT),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .ZERO(ZERO), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    // External slice: optional input inversion, then AND / OR / full-add / LESS pass-through.
    logic sa, sb;
    assign sa = SL_A ^ SL_AIN;
    assign sb = SL_B ^ SL_BIN;
    assign SL_COUT = (sa & sb) | (sa & SL_CIN) | (sb & SL_CIN);
    always_comb begin
        SL_RESULT = 1'b0;
        case (SL_OP)
            2'b00: SL_RESULT = sa & sb;
            2'b01: SL_RESULT = sa | sb;
            2'b10: SL_RESULT = sa ^ sb ^ SL_CIN;
            default: SL_RESULT = SL_LESS;
        endcase
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one operation from IDLE, leaves the bench in the following IDLE cycle.
    task automatic op_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] op, input int exp_lat, input logic [7:0] exp_res,
                            input logic exp_zero, input logic exp_ovf);
        int lat;
        logic busy_ok;
        logic [1:0] fx_op;
        logic fx_less;
        OPA = a; OPB = b; ALUOP = op; START = 1'b1;
        tick();
        START = 1'b0;
        lat = 0; busy_ok = 1'b1; fx_op = 2'b00; fx_less = 1'b0;
        while (DONE !== 1'b1 && lat < 20) begin
            if (BUSY !== 1'b1) busy_ok = 1'b0;
            if (SL_OP === 2'b11) begin
                fx_op = SL_OP;
                fx_less = SL_LESS;
            end
            tick();
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, RESULT, exp_res);
        chk({tag, "_zero"}, ZERO, exp_zero);
        chk({tag, "_ovf"}, OVERFLOW, exp_ovf);
        chk({tag, "_busy"}, busy_ok, 1'b1);
        chk({tag, "_busy_fin"}, BUSY, 1'b0);
        if (op[1:0] == 2'b11) begin
            chk({tag, "_fix_op"}, fx_op, 2'b11);
            chk({tag, "_fix_less"}, fx_less, exp_res[0]);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int gap;
        logic seen;
        RST = 1'b1; START = 1'b0; OPA = '0; OPB = '0; ALUOP = '0;
        tick(); tick();
        chk("rst_busy", BUSY, 1'b0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_result", RESULT, 8'h00);
        chk("rst_zero", ZERO, 1'b0);
        chk("rst_ovf", OVERFLOW, 1'b0);
        chk("rst_sl", {SL_A, SL_B, SL_AIN, SL_BIN, SL_CIN, SL_LESS, SL_OP}, 8'h00);
        RST = 1'b0;
        tick();

        op_check("add_5_3", 8'h05, 8'h03, 4'b0010, 8, 8'h08, 1'b0, 1'b0);
        op_check("sub_7f_ff", 8'h7F, 8'hFF, 4'b0110, 8, 8'h80, 1'b0, 1'b1);
        op_check("sub_5_5", 8'h05, 8'h05, 4'b0110, 8, 8'h00, 1'b1, 1'b0);
        op_check("slt_80_01", 8'h80, 8'h01, 4'b0111, 9, 8'h01, 1'b0, 1'b1);
        op_check("slt_01_80", 8'h01, 8'h80, 4'b0111, 9, 8'h00, 1'b1, 1'b1);
        op_check("slt_7f_80", 8'h7F, 8'h80, 4'b0111, 9, 8'h00, 1'b1, 1'b1);
        op_check("nor", 8'h0F, 8'h33, 4'b1100, 8, 8'hC0, 1'b0, 1'b0);
        op_check("and", 8'hF0, 8'h0F, 4'b0000, 8, 8'h00, 1'b1, 1'b0);
        op_check("or", 8'hF0, 8'h0F, 4'b0001, 8, 8'hFF, 1'b0, 1'b0);

        // START re-pulsed with different operands during SHIFT cycle 3
        OPA = 8'h05; OPB = 8'h03; ALUOP = 4'b0010; START = 1'b1;
        tick();
        START = 1'b0;
        repeat (3) tick();
        START = 1'b1; OPA = 8'hFF; OPB = 8'hFF; ALUOP = 4'b0110;
        tick();
        START = 1'b0; OPA = 8'h00; OPB = 8'h00;
        lat = 4;
        while (DONE !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("ign_lat", lat, 8);
        chk("ign_res", RESULT, 8'h08);
        tick(); tick();
        chk("ign_no_restart", BUSY, 1'b0);

        // Reset during SHIFT cycle 4
        OPA = 8'h05; OPB = 8'h03; ALUOP = 4'b0110; START = 1'b1;
        tick();
        START = 1'b0;
        repeat (4) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("abort_busy", BUSY, 1'b0);
        chk("abort_result", RESULT, 8'h00);
        chk("abort_sl", {SL_A, SL_B, SL_AIN, SL_BIN, SL_CIN, SL_LESS, SL_OP}, 8'h00);
        chk("abort_done", DONE, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (DONE === 1'b1) seen = 1'b1;
        end
        chk("abort_no_done", seen, 1'b0);

        // START held high across two ADDs
        OPA = 8'h01; OPB = 8'h01; ALUOP = 4'b0010; START = 1'b1;
        tick();
        OPA = 8'h02; OPB = 8'h02;
        lat = 0;
        while (DONE !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("b2b_lat1", lat, 8);
        chk("b2b_res1", RESULT, 8'h02);
        gap = 0;
        do begin
            tick();
            gap++;
            if (BUSY === 1'b1) START = 1'b0;
        end while (DONE !== 1'b1 && gap < 30);
        START = 1'b0;
`ifdef ULA_BACK2BACK_EN
        chk("b2b_gap", gap, 9);
`else
        chk("b2b_gap", gap, 10);
`endif
        chk("b2b_res2", RESULT, 8'h04);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ula_serial_ctrl.md
Name: ula_serial_ctrl

Overview:
Bit-serial sequencer that drives one external 1-bit ula slice and collects its outputs. It accepts WIDTH-bit operands plus a 4-bit ALU control word, then feeds the slice LSB-first, one bit per cycle. Carry is recirculated from slice COUT to CIN through a flop. Results are assembled into a WIDTH-bit word with ZERO and OVERFLOW flags. This lets a datapath use a single slice instead of a WIDTH-slice ripple chain.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous, active-high reset
START  input  1  request; sampled only in IDLE
OPA  input  WIDTH  operand A, captured when START accepted
OPB  input  WIDTH  operand B, captured when START accepted
ALUOP  input  4  {AINVERT, BINVERT, OPERATION[1:0]}, captured with operands
SL_A  output  1  slice A input
SL_B  output  1  slice B input
SL_AIN  output  1  slice AIN
SL_BIN  output  1  slice BIN
SL_CIN  output  1  slice CIN
SL_LESS  output  1  slice LESS
SL_OP  output  2  slice OPERATION
SL_RESULT  input  1  slice RESULT
SL_COUT  input  1  slice COUT
BUSY  output  1  high from START acceptance until DONE
DONE  output  1  one-cycle pulse; RESULT and flags valid from this cycle on
RESULT  output  WIDTH  assembled result
ZERO  output  1  RESULT == 0
OVERFLOW  output  1  signed overflow of the add/sub pass

Behaviour:
- Clocking and reset: one clock, CLK. RST is synchronous, active-high. RST forces IDLE and clears all registers. All outputs reset to 0, including every SL_* output.
- FSM states: IDLE, SHIFT, FIXUP, FIN.
- IDLE: if START=1, capture OPA, OPB and ALUOP. Set bit counter to 0, carry flop to BINVERT, BUSY=1, then go to SHIFT. Otherwise all SL_* outputs are held at 0.
- SHIFT, one bit per cycle, bit i = counter:
  - SL_A=A[i], SL_B=B[i], SL_AIN=AINVERT, SL_BIN=BINVERT, SL_CIN=carry flop, SL_LESS=0.
  - SL_OP=OPERATION, except OPERATION=11 drives 10 (add pass).
  - Each edge: shift SL_RESULT into RESULT from the MSB side (right shift), carry flop <= SL_COUT.
- At i=WIDTH-1 (add/slt only, i.e. OPERATION[1]=1):
  - OVERFLOW <= SL_CIN ^ SL_COUT.
  - set <= SL_RESULT ^ (SL_CIN ^ SL_COUT).
  - For OPERATION[1]=0, OVERFLOW <= 0.
- After WIDTH SHIFT cycles: go to FIXUP if OPERATION=11, else go to FIN.
- FIXUP (one cycle): SL_OP=11, SL_LESS=set, SL_A/SL_B=0. RESULT <= {WIDTH-1 zeros, SL_RESULT}.
- FIN (one cycle): DONE=1, BUSY=0, ZERO=(RESULT==0). Then return to IDLE.
- Output holding: RESULT, ZERO and OVERFLOW hold until the next accepted START. On acceptance, ZERO and OVERFLOW clear to 0.
- Latency: FIN is entered on the WIDTH-th edge after the START-sampling edge (WIDTH+1 for SLT). Throughput: one operation per WIDTH+2 cycles (WIDTH+3 for SLT).
- START in SHIFT, FIXUP or FIN is ignored; captured operands are unaffected.
- RST mid-operation aborts immediately: no DONE, RESULT=0.
- Every ALUOP encoding is legal; the slice semantics apply directly. Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
- OPERATION=11 with AINVERT/BINVERT produces a signed-less-than of the inverted operands.
- Arithmetic is modulo 2^WIDTH; the final carry is discarded.

Optional Feature:
Macro ULA_BACK2BACK_EN.
- Defined: START=1 during FIN is accepted. Operands are captured as in IDLE and the next state is SHIFT, so DONE and BUSY are both high in that cycle.
- Not defined: START during FIN is ignored, and a new START is accepted only from IDLE.

Test Plan:
1. WIDTH=8, ADD OPA=0x05 OPB=0x03 ALUOP=0010 -> DONE 8 cycles after START edge, RESULT=0x08, ZERO=0, OVERFLOW=0, BUSY high throughout.
2. SUB OPA=0x7F OPB=0xFF ALUOP=0110 -> RESULT=0x80, OVERFLOW=1; SUB 0x05-0x05 -> RESULT=0x00, ZERO=1.
3. SLT ALUOP=0111, each DONE at 9 cycles, SL_OP=11 and SL_LESS=set during FIXUP:
   - 0x80,0x01 -> RESULT=0x01.
   - 0x01,0x80 -> 0x00.
   - 0x7F,0x80 (overflow case) -> 0x00 with OVERFLOW=1.
4. Logic ops: NOR 0x0F,0x33 ALUOP=1100 -> 0xC0; AND 0xF0,0x0F -> 0x00 with ZERO=1; OR 0xF0,0x0F -> 0xFF. OVERFLOW=0 for all three.
5. START pulsed again during SHIFT cycle 3 -> ignored, result unchanged. Separate run: RST at SHIFT cycle 4 -> next cycle BUSY=0, RESULT=0, all SL_*=0, no DONE.
6. ULA_BACK2BACK_EN on: START held high with ADD 1+1 then ADD 2+2 -> DONE pulses 9 cycles apart, RESULT 0x02 then 0x04. Macro off: second START during FIN ignored, and the operation is accepted in the following IDLE cycle.
